// File: rtl/ofmap_drain.sv
// rtl/ofmap_drain.sv - output vector collector with valid/ready drain stream
//
// Ports:
//   clk, rst           single rising-edge clock, asynchronous active-high reset
//   matrix_in          nPEx x outputSize vector (channel c at matrix_in[c])
//   in_valid           capture matrix_in this cycle
//   in_done            level; its rising edge ends collection and starts the drain
//   out_data/out_channel/out_pixel/out_last/out_valid, out_ready
//                      drain stream, pixel-major / channel-minor
//   frame_count        pixels stored in the current frame
//   flag_overflow      sticky, a vector was dropped (cleared by the next frame)
//   flag_busy          collecting or draining
//   flag_drained       one-cycle pulse when a frame completes (or an empty done)
module ofmap_drain #(
    parameter int outputSize = 17,
    parameter int nPEx       = 3,
    parameter int numEntries = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [nPEx-1:0][outputSize-1:0]     matrix_in,
    input  logic                                in_valid,
    input  logic                                in_done,
    output logic signed [outputSize-1:0]        out_data,
    output logic [$clog2(nPEx)-1:0]             out_channel,
    output logic [$clog2(numEntries)-1:0]       out_pixel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic [$clog2(numEntries):0]         frame_count,
    output logic                                flag_overflow,
    output logic                                flag_busy,
    output logic                                flag_drained
);

    localparam int CW = $clog2(nPEx);
    localparam int PW = $clog2(numEntries);
    localparam int FW = PW + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t state, state_next;

    logic [nPEx-1:0][outputSize-1:0] mem [numEntries];

    logic done_prev;
    logic done_rise, full, transfer;

    logic                         wr_en;
    logic [PW-1:0]                wr_idx;
    logic [PW-1:0]                rd_pix;
    logic [CW-1:0]                rd_ch;
    logic                         rd_load;

    logic signed [outputSize-1:0] n_data;
    logic [CW-1:0]                n_channel;
    logic [PW-1:0]                n_pixel;
    logic                         n_valid, n_last;
    logic [FW-1:0]                n_count;
    logic                         n_overflow, n_busy, n_drained;

    assign done_rise = in_done && !done_prev;
    assign full      = (frame_count == FW'(numEntries));
    assign transfer  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A vector arriving with the done edge is captured and drained as a one-pixel frame
                if (in_valid) state_next = done_rise ? DRAIN : COLLECT;
            end
            COLLECT: begin
                if (done_rise) state_next = DRAIN;
            end
            DRAIN: begin
                if (transfer && out_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and buffer write control
    always_comb begin
        n_data     = out_data;
        n_channel  = out_channel;
        n_pixel    = out_pixel;
        n_valid    = out_valid;
        n_last     = out_last;
        n_count    = frame_count;
        n_overflow = flag_overflow;
        n_busy     = (state_next != IDLE);
        n_drained  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = frame_count[PW-1:0];
        rd_pix     = '0;
        rd_ch      = '0;
        rd_load    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    n_count    = FW'(1);
                    n_overflow = 1'b0;
                end else if (done_rise) begin
                    n_drained = 1'b1;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (full) begin
                        n_overflow = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        n_count = frame_count + FW'(1);
                    end
                end
            end
            DRAIN: begin
                if (in_valid) n_overflow = 1'b1;
                // First DRAIN cycle presents word (0,0); the extra cycle lets a vector
                // captured on the done edge land in the buffer before it is read.
                if (!out_valid) begin
                    rd_load = 1'b1;
                end else if (transfer) begin
                    if (out_last) begin
                        n_valid   = 1'b0;
                        n_last    = 1'b0;
                        n_count   = '0;
                        n_drained = 1'b1;
                    end else begin
                        rd_load = 1'b1;
                        if (out_channel == CW'(nPEx - 1)) begin
                            rd_pix = out_pixel + PW'(1);
                            rd_ch  = '0;
                        end else begin
                            rd_pix = out_pixel;
                            rd_ch  = out_channel + CW'(1);
                        end
                    end
                end
                if (rd_load) begin
                    n_valid   = 1'b1;
                    n_pixel   = rd_pix;
                    n_channel = rd_ch;
                    n_data    = $signed(mem[rd_pix][rd_ch]);
                    n_last    = ({1'b0, rd_pix} == frame_count - FW'(1)) &&
                                (rd_ch == CW'(nPEx - 1));
                end
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_prev     <= 1'b0;
            out_data      <= '0;
            out_channel   <= '0;
            out_pixel     <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            frame_count   <= '0;
            flag_overflow <= 1'b0;
            flag_busy     <= 1'b0;
            flag_drained  <= 1'b0;
        end else begin
            done_prev     <= in_done;
            out_data      <= n_data;
            out_channel   <= n_channel;
            out_pixel     <= n_pixel;
            out_valid     <= n_valid;
            out_last      <= n_last;
            frame_count   <= n_count;
            flag_overflow <= n_overflow;
            flag_busy     <= n_busy;
            flag_drained  <= n_drained;
        end
    end

    // Buffer storage; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= matrix_in;
    end

endmodule

// File: tb/tb_ofmap_drain.sv
// tb/tb_ofmap_drain.sv - directed self-checking bench for ofmap_drain
module tb_ofmap_drain;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0][16:0]     matrix_in;
    logic                 in_valid;
    logic                 in_done;
    logic signed [16:0]   out_data;
    logic [1:0]           out_channel;
    logic [3:0]           out_pixel;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [4:0]           frame_count;
    logic                 flag_overflow;
    logic                 flag_busy;
    logic                 flag_drained;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ofmap_drain #(.outputSize(17), .nPEx(3), .numEntries(16)) dut (
        .clk(clk), .rst(rst), .matrix_in(matrix_in), .in_valid(in_valid), .in_done(in_done),
        .out_data(out_data), .out_channel(out_channel), .out_pixel(out_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_count(frame_count), .flag_overflow(flag_overflow), .flag_busy(flag_busy),
        .flag_drained(flag_drained)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pixel p (0-based) carries vector (k, 2k, -k) with k = p+1
    function automatic int vword(input int p, input int c);
        int k = p + 1;
        return (c == 0) ? k : (c == 1) ? 2 * k : -k;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_last"}, int'(out_last), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_idx"}, int'(out_channel) + 4 * int'(out_pixel), 0);
        check({tag, "_count"}, int'(frame_count), 0);
        check({tag, "_flags"}, int'({flag_overflow, flag_busy, flag_drained}), 0);
    endtask

    // Send vectors 1..n; simul puts in_done on the cycle of the last vector
    task automatic send_frame(input int n, input bit simul);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k >= 2) check("cap_count", int'(frame_count), (k - 1 > 16) ? 16 : k - 1);
            in_valid     = 1'b1;
            matrix_in[0] = 17'(k);
            matrix_in[1] = 17'(2 * k);
            matrix_in[2] = 17'(-k);
            if (simul && k == n) in_done = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!simul) begin
            check("pre_count", int'(frame_count), (n > 16) ? 16 : n);
            check("pre_overflow", int'(flag_overflow), (n > 16) ? 1 : 0);
            check("pre_busy", int'(flag_busy), 1);
            in_done = 1'b1;
            @(negedge clk);
        end
        in_done = 1'b0;
        check("lat_n0", int'(out_valid), 0);
    endtask

    // Drain npix pixels, stop once stop_after words have transferred
    task automatic drain(input int npix, input int stop_after, input bit bp);
        int idx = 0;
        int cyc = 0;
        bit held = 0;
        bit rdy;
        int hd = 0, hi = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int total = npix * 3;
        while (idx < stop_after && cyc < 500) begin
            @(negedge clk);
            rdy = bp ? pat[cyc % 4] : 1'b1;
            out_ready = rdy;
            if (cyc == 0) check("lat_n1", int'(out_valid), 1);
            if (held) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), hd);
                check("hold_idx", int'(out_channel) + 4 * int'(out_pixel) + 64 * int'(out_last), hi);
            end
            if (out_valid && rdy) begin
                check("word_data", int'(out_data), vword(idx / 3, idx % 3));
                check("word_idx", int'(out_channel) + 4 * int'(out_pixel), (idx % 3) + 4 * (idx / 3));
                check("word_last", int'(out_last), (idx == total - 1) ? 1 : 0);
                idx++;
            end
            held = out_valid && !rdy;
            hd = int'(out_data);
            hi = int'(out_channel) + 4 * int'(out_pixel) + 64 * int'(out_last);
            cyc++;
        end
        out_ready = 1'b1;
        check("xfer_count", idx, stop_after);
        if (stop_after == total) begin
            @(negedge clk);
            check("end_drained", int'(flag_drained), 1);
            check("end_count", int'(frame_count), 0);
            check("end_valid", int'(out_valid), 0);
            check("end_busy", int'(flag_busy), 0);
            @(negedge clk);
            check("end_pulse", int'(flag_drained), 0);
            check("end_quiet", int'(out_valid), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        matrix_in = '0;
        in_valid = 1'b0;
        in_done = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Basic frame
        send_frame(9, 1'b0);
        drain(9, 27, 1'b0);

        // Backpressure
        send_frame(9, 1'b0);
        drain(9, 27, 1'b1);

        // Overflow: 18 vectors into 16 entries, sticky through the drain
        send_frame(18, 1'b0);
        drain(16, 48, 1'b0);
        check("ovf_sticky", int'(flag_overflow), 1);

        // Simultaneous last vector and done; new frame clears overflow
        send_frame(4, 1'b1);
        check("simul_count", int'(frame_count), 4);
        check("simul_ovf_clr", int'(flag_overflow), 0);
        drain(4, 12, 1'b0);

        // Reset mid-drain after 5 words
        send_frame(9, 1'b0);
        drain(9, 5, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send_frame(2, 1'b0);
        drain(2, 6, 1'b0);

        // Empty done in IDLE, held high for two cycles: one pulse only
        @(negedge clk);
        in_done = 1'b1;
        @(negedge clk);
        check("empty_pulse", int'(flag_drained), 1);
        check("empty_valid", int'(out_valid), 0);
        @(negedge clk);
        in_done = 1'b0;
        check("empty_once", int'(flag_drained), 0);
        check("empty_busy", int'(flag_busy), 0);
        repeat (3) begin
            @(negedge clk);
            check("empty_novalid", int'(out_valid) + int'(flag_drained), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
